// File: rtl/sqemux_sel_ctrl_if.sv
// Request/acknowledge handshake between a switch requester and sqemux_sel_ctrl.
interface sqemux_sel_ctrl_if;
    logic req_valid;
    logic req_sel;
    logic abort;
    logic req_ready;
    logic done;
    logic aborted;

    modport master (
        output req_valid, req_sel, abort,
        input  req_ready, done, aborted
    );

    modport slave (
        input  req_valid, req_sel, abort,
        output req_ready, done, aborted
    );
endinterface

// File: rtl/sqemux_sel_ctrl.sv
// Sequencer for the SQEMUX dynamic clock mux: gate off, switch SELECT, settle, gate on,
// then acknowledge the requester. All outputs come straight from flops.
module sqemux_sel_ctrl #(
    parameter int unsigned OFF_CYCLES    = 4,
    parameter int unsigned SETTLE_CYCLES = 8,
    parameter int unsigned ON_CYCLES     = 2,
    parameter int unsigned CNT_W         = 8,
    parameter bit          RESET_SEL     = 1'b0
) (
    input  logic               clk,
    input  logic               resetn,
    sqemux_sel_ctrl_if.slave   bus,
    output logic               select,
    output logic               sen,
    output logic               den,
    output logic               dynen,
    output logic [15:0]        switch_cnt
);
    // A zero-length phase would collapse the glitch-safe ordering, so clamp to one cycle.
    localparam int unsigned N_OFF = (OFF_CYCLES    == 0) ? 1 : OFF_CYCLES;
    localparam int unsigned N_SET = (SETTLE_CYCLES == 0) ? 1 : SETTLE_CYCLES;
    localparam int unsigned N_ON  = (ON_CYCLES     == 0) ? 1 : ON_CYCLES;
    localparam logic [CNT_W-1:0] OFF_LD = CNT_W'(N_OFF - 1);
    localparam logic [CNT_W-1:0] SET_LD = CNT_W'(N_SET - 1);
    localparam logic [CNT_W-1:0] ON_LD  = CNT_W'(N_ON - 1);

    typedef enum logic [2:0] {IDLE, GATE_OFF, SWITCH, GATE_ON, ACK} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             sel_q;
    logic             aborting;
    logic             ready_q;
    logic             done_q;
    logic             aborted_q;
    logic [15:0]      cnt_q;

    assign bus.req_ready = ready_q;
    assign bus.done      = done_q;
    assign bus.aborted   = aborted_q;
    assign switch_cnt    = cnt_q;
    assign den           = 1'b0;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            sel_q     <= RESET_SEL;
            aborting  <= 1'b0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            cnt_q     <= '0;
            select    <= RESET_SEL;
            sen       <= 1'b1;
            dynen     <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.req_valid && ready_q) begin
                        ready_q <= 1'b0;
                        sel_q   <= bus.req_sel;
                        if (bus.req_sel == select) begin
                            state  <= ACK;
                            done_q <= 1'b1;
                        end else begin
                            state    <= GATE_OFF;
                            sen      <= 1'b0;
                            dynen    <= 1'b1;
                            cnt      <= OFF_LD;
                            aborting <= 1'b0;
                        end
                    end
                end
                GATE_OFF: begin
                    // Abort is only safe here: SELECT has not moved yet.
                    if (bus.abort) begin
                        state    <= GATE_ON;
                        sen      <= 1'b1;
                        cnt      <= ON_LD;
                        aborting <= 1'b1;
                    end else if (cnt == '0) begin
                        state  <= SWITCH;
                        select <= sel_q;
                        cnt    <= SET_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                SWITCH: begin
                    if (cnt == '0) begin
                        state <= GATE_ON;
                        sen   <= 1'b1;
                        cnt   <= ON_LD;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                GATE_ON: begin
                    if (cnt == '0) begin
                        state     <= ACK;
                        done_q    <= 1'b1;
                        aborted_q <= aborting;
                        dynen     <= 1'b0;
                        if (!aborting && cnt_q != 16'hFFFF)
                            cnt_q <= cnt_q + 16'd1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ACK: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
